// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single write port of the register file among NUM_REQ requesters.
// Round-robin arbitration lets the current owner keep the port for up to
// MAX_BURST consecutive transfers while someone else is waiting. With no
// competition the owner keeps the port indefinitely. Each requester uses a
// valid/ready handshake. The write outputs are registered and drive the
// register file write port directly.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  [NUM_REQ]         per-requester write request
//   req_addr_i   [NUM_REQ*ADDR_W]  packed addresses, requester i at i*ADDR_W
//   req_data_i   [NUM_REQ*DATA_W]  packed data, requester i at i*DATA_W
//   req_ready_o  [NUM_REQ]         one-hot (or zero) accept
//   stall_i      downstream hold, blocks every transfer
//   wr_en_o / wr_addr_o / wr_data_o   registered register-file write port
//   wr_src_o     requester that produced the current write
//   owner_o      current owner (meaningful while busy_o=1)
//   r0_drop_o    (only with REGFILE_WR_ARB_R0_PROTECT_EN) pulse when a
//                write to register 0 was accepted but suppressed
//   busy_o       an owner holds the port
//
// Optional build macro: REGFILE_WR_ARB_R0_PROTECT_EN makes register 0
// read-only. Writes to address 0 still complete the handshake and count
// toward the burst, but they never reach the register file.
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      stall_i,
    output logic                      wr_en_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic [SRC_W-1:0]          wr_src_o,
    output logic [SRC_W-1:0]          owner_o,
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
    output logic                      r0_drop_o,
`endif
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Unpacked views of the flat request buses
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
    end

    // State
    state_e             state_q,     state_d;
    logic [SRC_W-1:0]   owner_q,     owner_d;
    logic [SRC_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q,   wr_data_d;
    logic [SRC_W-1:0]   wr_src_q,    wr_src_d;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
    logic               r0_drop_q,   r0_drop_d;
`endif

    // Winner selection
    logic [NUM_REQ-1:0] owner_oh;
    logic               others_vld;
    logic               keep_owner;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   scan_idx;
    logic [SRC_W-1:0]   next_ptr;

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign others_vld = |(req_valid_i & ~owner_oh);
    // The owner may continue while under its burst budget, or beyond it
    // when nobody else is asking.
    assign keep_owner = (state_q == OWN) && req_valid_i[owner_q] &&
                        ((burst_cnt_q < CNT_W'(MAX_BURST)) || !others_vld);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        if (!stall_i && !rst_i) begin
            if (keep_owner) begin
                win_found = 1'b1;
                win_idx   = owner_q;
            end else begin
                // Scan from the far end back toward rr_ptr so the valid
                // index nearest rr_ptr is the last one written and wins.
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    scan_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                    if (req_valid_i[scan_idx]) begin
                        win_found = 1'b1;
                        win_idx   = scan_idx;
                    end
                end
            end
        end
    end

    assign req_ready_o = win_found ? (NUM_REQ'(1) << win_idx) : '0;
    assign next_ptr    = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Next state and registered write port
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_src_d    = wr_src_q;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
        r0_drop_d   = 1'b0;
`endif

        if (win_found) begin
            // A winner always has valid=1, so winning is a transfer.
            wr_en_d   = 1'b1;
            wr_addr_d = addr_arr[win_idx];
            wr_data_d = data_arr[win_idx];
            wr_src_d  = win_idx;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
            if (addr_arr[win_idx] == '0) begin
                wr_en_d   = 1'b0;
                r0_drop_d = 1'b1;
            end
`endif
            if (state_q == OWN && win_idx == owner_q) begin
                if (burst_cnt_q != CNT_W'(MAX_BURST))
                    burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                state_d     = OWN;
                owner_d     = win_idx;
                burst_cnt_d = CNT_W'(1);
                rr_ptr_d    = next_ptr;
            end
        end else if (!stall_i) begin
            // Idle cycle without a stall releases ownership; a stall
            // leaves everything frozen.
            state_d     = IDLE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_src_q    <= '0;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
            r0_drop_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_src_q    <= wr_src_d;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
            r0_drop_q   <= r0_drop_d;
`endif
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_src_o  = wr_src_q;
    assign owner_o   = owner_q;
    assign busy_o    = (state_q == OWN);
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
    assign r0_drop_o = r0_drop_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] data = '0;
    logic            stall = 1'b0;
    logic [N-1:0]    ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      wr_src;
    logic [1:0]      owner;
    logic            busy;
    logic            drop;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
        .req_ready_o(ready), .stall_i(stall),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_src_o(wr_src), .owner_o(owner),
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
        .r0_drop_o(drop),
`endif
        .busy_o(busy)
    );

`ifndef REGFILE_WR_ARB_R0_PROTECT_EN
    assign drop = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Requester protocol: a pending request holds valid/addr/data until accepted.
    logic [N-1:0]    pv = '0, pr = '0;
    logic [N*AW-1:0] pa = '0;
    logic [N*DW-1:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (pv[i] && !pr[i])
                    assert (valid[i] && addr[i*AW +: AW] == pa[i*AW +: AW] &&
                            data[i*DW +: DW] == pd[i*DW +: DW])
                    else $error("requester %0d changed a pending request", i);
            pv <= valid; pr <= ready; pa <= addr; pd <= data;
        end
    end

    // Behavioural model: ownership, burst count and round-robin start point.
    bit              m_owned;
    int              m_owner, m_cnt, m_ptr;
    logic            e_en, e_drop;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_data;
    logic [1:0]      e_src;

    task automatic model_reset;
        m_owned = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        e_en = 0; e_drop = 0; e_addr = '0; e_data = '0; e_src = '0;
    endtask

    function automatic int model_win();
        bit others = 0;
        if (stall) return -1;
        for (int i = 0; i < N; i++) if (i != m_owner && valid[i]) others = 1;
        if (m_owned && valid[m_owner] && (m_cnt < MB || !others)) return m_owner;
        for (int k = 0; k < N; k++) if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_commit(input int w);
        e_en = 0; e_drop = 0;
        if (w >= 0) begin
            e_addr = addr[w*AW +: AW];
            e_data = data[w*DW +: DW];
            e_src  = 2'(w);
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
            e_en = (e_addr != 0); e_drop = (e_addr == 0);
`else
            e_en = 1;
`endif
        end
        if (!stall) begin
            if (w >= 0) begin
                if (m_owned && w == m_owner) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                else begin m_owned = 1; m_owner = w; m_cnt = 1; m_ptr = (w + 1) % N; end
            end else begin
                m_owned = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic apply_reset;
        rst = 1; valid = '0; stall = 0; addr = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1; valid = '1; addr = 16'h4321; data = '1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++; if (ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", ready); end
        end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_addr !== 4'd0 || wr_data !== 16'd0 || wr_src !== 2'd0) begin
            errors++; $display("FAIL reset_wr_port got %h/%h/%0d want 0/0/0", wr_addr, wr_data, wr_src); end
        checks++; if (busy !== 1'b0 || owner !== 2'd0 || drop !== 1'b0) begin
            errors++; $display("FAIL reset_state got busy %b owner %0d drop %b want 0 0 0", busy, owner, drop); end
        valid = '0; addr = '0; data = '0;
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        apply_reset();
        valid = 4'b0001; addr[3:0] = 4'd6; data[15:0] = 16'd25;
        @(negedge clk);
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", ready); end
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd6 || wr_data !== 16'd25 || wr_src !== 2'd0) begin
            errors++; $display("FAIL single_write got en %b a %0d d %0d s %0d want 1 6 25 0", wr_en, wr_addr, wr_data, wr_src); end
        valid = '0;
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'd6) begin
            errors++; $display("FAIL single_idle got en %b a %0d want 0 6", wr_en, wr_addr); end
    endtask

    task automatic test_all_valid;
        apply_reset();
        for (int i = 0; i < N; i++) begin addr[i*AW +: AW] = 4'(i); data[i*DW +: DW] = 16'(i << 4); end
        valid = '1;
        for (int c = 0; c < 20; c++) begin
            int g = (c / MB) % N;
            @(negedge clk);
            checks++; if (ready !== 4'(1 << g)) begin
                errors++; $display("FAIL rr_ready cycle %0d got %b want %b", c, ready, 4'(1 << g)); end
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b1 || wr_src !== 2'(g) || wr_addr !== 4'(g) || wr_data !== 16'(g << 4)) begin
                errors++; $display("FAIL rr_write cycle %0d got en %b s %0d a %0d d %h want src %0d", c, wr_en, wr_src, wr_addr, wr_data, g); end
        end
    endtask

    task automatic test_solo_burst;
        apply_reset();
        valid = 4'b0100; addr[8 +: 4] = 4'd9; data[32 +: 16] = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL solo_ready cycle %0d got %b want 0100", c, ready); end
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b1 || wr_src !== 2'd2 || busy !== 1'b1 || owner !== 2'd2) begin
                errors++; $display("FAIL solo_write cycle %0d got en %b s %0d busy %b own %0d want 1 2 1 2", c, wr_en, wr_src, busy, owner); end
        end
    endtask

    task automatic test_stall;
        // grant per cycle; -1 = stalled
        int exp_g [8] = '{1, 1, -1, -1, -1, 1, 1, 3};
        apply_reset();
        valid = 4'b1010; addr[4 +: 4] = 4'd1; addr[12 +: 4] = 4'd3;
        data[16 +: 16] = 16'h1111; data[48 +: 16] = 16'h3333;
        for (int c = 0; c < 8; c++) begin
            stall = (exp_g[c] < 0);
            @(negedge clk);
            checks++; if (ready !== (exp_g[c] < 0 ? 4'b0 : 4'(1 << exp_g[c]))) begin
                errors++; $display("FAIL stall_ready cycle %0d got %b want grant %0d", c, ready, exp_g[c]); end
            @(posedge clk); #1;
            checks++; if (wr_en !== (exp_g[c] >= 0) || busy !== 1'b1 ||
                          (exp_g[c] >= 0 && wr_src !== 2'(exp_g[c]))) begin
                errors++; $display("FAIL stall_write cycle %0d got en %b s %0d busy %b want grant %0d", c, wr_en, wr_src, busy, exp_g[c]); end
        end
        stall = 0;
    endtask

    task automatic test_async_reset;
        logic [3:0] a0;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
        a0 = 4'd5;
`else
        a0 = 4'd0;
`endif
        apply_reset();
        valid = 4'b0001; addr[3:0] = a0; data[15:0] = 16'd64;
        @(posedge clk); #1;
        valid = '0;
        checks++; if (wr_en !== 1'b1 || wr_data !== 16'd64 || wr_addr !== a0) begin
            errors++; $display("FAIL arst_pre got en %b a %0d d %0d want 1 %0d 64", wr_en, wr_addr, wr_data, a0); end
        #2 rst = 1;
        #1;
        checks++; if (wr_en !== 1'b0 || wr_data !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_drop got en %b d %0d busy %b want 0 0 0", wr_en, wr_data, busy); end
        @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        valid = '1;
        @(negedge clk);
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL arst_restart got %b want 0001", ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_r0;
        apply_reset();
        valid = 4'b1000; addr[12 +: 4] = 4'd0; data[48 +: 16] = 16'hFFFF;
        @(negedge clk);
        checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL r0_ready got %b want 1000", ready); end
        @(posedge clk); #1;
        valid = '0;
`ifdef REGFILE_WR_ARB_R0_PROTECT_EN
        checks++; if (wr_en !== 1'b0 || drop !== 1'b1) begin
            errors++; $display("FAIL r0_drop got en %b drop %b want 0 1", wr_en, drop); end
        @(posedge clk); #1;
        checks++; if (drop !== 1'b0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL r0_pulse got en %b drop %b want 0 0", wr_en, drop); end
`else
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'hFFFF || wr_src !== 2'd3) begin
            errors++; $display("FAIL r0_write got en %b a %0d d %h s %0d want 1 0 ffff 3", wr_en, wr_addr, wr_data, wr_src); end
`endif
    endtask

    task automatic test_random;
        int w;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            w = model_win();
            checks++; if (ready !== (w < 0 ? 4'b0 : 4'(1 << w))) begin
                errors++; $display("FAIL rand_ready cycle %0d got %b want winner %0d", c, ready, w); end
            @(posedge clk); #1;
            model_commit(w);
            checks++; if (wr_en !== e_en || wr_addr !== e_addr || wr_data !== e_data || wr_src !== e_src || drop !== e_drop) begin
                errors++; $display("FAIL rand_write cycle %0d got %b %h %h %0d %b want %b %h %h %0d %b",
                                   c, wr_en, wr_addr, wr_data, wr_src, drop, e_en, e_addr, e_data, e_src, e_drop); end
            checks++; if (busy !== m_owned || (m_owned && owner !== 2'(m_owner))) begin
                errors++; $display("FAIL rand_owner cycle %0d got busy %b own %0d want %b %0d", c, busy, owner, m_owned, m_owner); end
            if (w >= 0) valid[w] = 0;
            for (int i = 0; i < N; i++)
                if (!valid[i] && $urandom_range(0, 3) == 0) begin
                    valid[i] = 1;
                    addr[i*AW +: AW] = 4'($urandom);
                    data[i*DW +: DW] = 16'($urandom);
                end
            stall = ($urandom_range(0, 7) == 0);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_solo_burst();
        test_stall();
        test_async_reset();
        test_r0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
